// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the 8x4 keypad scanner.
//   NUM_COLS / NUM_ROWS : matrix geometry
//   col_t, row_t        : column / row indices
//   key_code_t          : {col, row} code handed to the consumer
//   scan_state_t        : scanner FSM states
//   prio_row()          : lowest-set-bit row encoder (row 0 has priority)
package keypad_pkg;

    localparam int NUM_COLS = 8;
    localparam int NUM_ROWS = 4;

    typedef logic [2:0] col_t;
    typedef logic [1:0] row_t;

    typedef struct packed {
        col_t col;
        row_t row;
    } key_code_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } scan_state_t;

    // Walk from the top row down so the lowest set row is the last one written.
    function automatic row_t prio_row(input logic [NUM_ROWS-1:0] r);
        row_t idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (r[i]) begin
                idx = row_t'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d_i   : asynchronous input bus
//   q_o   : synchronized output bus (two clk cycles of latency)
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans an 8-column x 4-row key matrix, debounces presses and
// releases, and presents key codes on a valid/ready interface.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   en        : scan enable (0 parks the scanner, handshake keeps working)
//   rows      : raw active-high row lines, asynchronous to clk
//   col_sel   : column index for the external 3-to-8 strobe decoder
//   key_valid : key_code holds an unconsumed key
//   key_ready : consumer takes key_code when key_valid && key_ready
//   key_code  : {column[2:0], row[1:0]}
//   dropped   : one-cycle pulse when a debounced key found the output full
module keypad_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] rows,
    output logic [2:0] col_sel,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [4:0] key_code,
    output logic       dropped
);
    import keypad_pkg::*;

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX  = 4'(DEBOUNCE);
    // The DEBOUNCE parameter shadows the state literal of the same name.
    localparam scan_state_t     ST_DEB   = keypad_pkg::DEBOUNCE;

    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_q, div_d;
    scan_state_t      state_q, state_d;
    col_t             col_q, col_d;
    row_t             cap_row_q, cap_row_d;
    col_t             cap_col_q, cap_col_d;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       deb_inc_s;
    logic             sample_s;
    logic             hit_s;
    logic             emit_s;
    logic             valid_q, valid_d;
    key_code_t        code_q, code_d;
    logic             drop_q, drop_d;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rows),
        .q_o   (rows_s)
    );

    assign sample_s  = en && (div_q == DIV_LAST);
    assign hit_s     = rows_s[cap_row_q];
    assign deb_inc_s = (deb_q == DEB_MAX) ? deb_q : (deb_q + 4'd1);

    // Dwell counter: free-runs while enabled, parked at zero otherwise.
    always_comb begin
        div_d = div_q;
        if (!en) begin
            div_d = {DIV_W{1'b0}};
        end else if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Scan/debounce FSM next state; decisions happen only at sample points.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        deb_d     = deb_q;
        cap_col_d = cap_col_q;
        cap_row_d = cap_row_q;
        emit_s    = 1'b0;
        if (!en) begin
            state_d = SCAN;
            deb_d   = 4'd0;
        end else if (sample_s) begin
            case (state_q)
                SCAN: begin
                    if (rows_s != 4'b0000) begin
                        cap_col_d = col_q;
                        cap_row_d = prio_row(rows_s);
                        if (DEB_MAX == 4'd1) begin
                            emit_s  = 1'b1;
                            state_d = RELEASE;
                            deb_d   = 4'd0;
                        end else begin
                            state_d = ST_DEB;
                            deb_d   = 4'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                ST_DEB: begin
                    if (hit_s) begin
                        if (deb_inc_s == DEB_MAX) begin
                            emit_s  = 1'b1;
                            state_d = RELEASE;
                            deb_d   = 4'd0;
                        end else begin
                            deb_d = deb_inc_s;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 3'd1;
                        deb_d   = 4'd0;
                    end
                end
                RELEASE: begin
                    // deb_cnt here counts consecutive samples with the key up.
                    if (!hit_s) begin
                        if (deb_inc_s == DEB_MAX) begin
                            state_d = SCAN;
                            col_d   = col_q + 3'd1;
                            deb_d   = 4'd0;
                        end else begin
                            deb_d = deb_inc_s;
                        end
                    end else begin
                        deb_d = 4'd0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    deb_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output slot: load on emit if empty or being drained, else flag a drop.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        drop_d  = 1'b0;
        if (emit_s) begin
            if (!valid_q || key_ready) begin
                valid_d = 1'b1;
                code_d  = '{col: cap_col_d, row: cap_row_d};
            end else begin
                drop_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= {DIV_W{1'b0}};
            state_q   <= SCAN;
            col_q     <= 3'd0;
            deb_q     <= 4'd0;
            cap_col_q <= 3'd0;
            cap_row_q <= 2'd0;
            valid_q   <= 1'b0;
            code_q    <= 5'd0;
            drop_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            col_q     <= col_d;
            deb_q     <= deb_d;
            cap_col_q <= cap_col_d;
            cap_row_q <= cap_row_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            drop_q    <= drop_d;
        end
    end

    assign col_sel   = col_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign dropped   = drop_q;

endmodule
